// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared opcode constants, widths and update actions for the branch predictor
package branch_predictor_pkg;

    localparam int BP_DBITS = 16;

    localparam logic [3:0] OP1_BEQ = 4'h8;
    localparam logic [3:0] OP1_BNE = 4'h9;
    localparam logic [3:0] OP1_JMP = 4'hA;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_HIT   = 2'd1,
        ACT_ALLOC = 2'd2,
        ACT_FLUSH = 2'd3
    } upd_action_e;

    function automatic logic is_ctrl_op(input logic [3:0] op);
        return (op == OP1_BEQ) || (op == OP1_BNE) || (op == OP1_JMP);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up/down saturating counter with force-max and load, resets to weakly not-taken
module sat_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             force_max,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_VALUE   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] RESET_VALUE = MAX_VALUE >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (force_max) begin
            count <= MAX_VALUE;
        end else if (inc) begin
            if (count != MAX_VALUE) begin
                count <= count + 1'b1;
            end
        end else if (dec) begin
            if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped branch target buffer with saturating direction counters
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int DBITS    = BP_DBITS,
    parameter int IDXBITS  = 4,
    parameter int CTRBITS  = 2,
    parameter int STATBITS = 16
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [DBITS-1:0]    LK_PC,
    output logic                PRED_TAKEN,
    output logic [DBITS-1:0]    PRED_TARGET,
    input  logic                UPD_VALID,
    input  logic [DBITS-1:0]    UPD_PC,
    input  logic                UPD_ISJMP,
    input  logic                UPD_TAKEN,
    input  logic [DBITS-1:0]    UPD_TARGET,
    input  logic                INV,
    output logic [STATBITS-1:0] UPD_CNT,
    output logic [STATBITS-1:0] MISP_CNT
);

    localparam int ENTRIES = 1 << IDXBITS;
    localparam int TAGBITS = DBITS - IDXBITS - 1;

    logic [ENTRIES-1:0] valid;
    logic [TAGBITS-1:0] tags    [ENTRIES];
    logic [DBITS-1:0]   targets [ENTRIES];
    logic [CTRBITS-1:0] ctrs    [ENTRIES];

    logic [IDXBITS-1:0] lk_idx;
    logic [TAGBITS-1:0] lk_tag;
    logic               lk_hit;

    logic [IDXBITS-1:0] up_idx;
    logic [TAGBITS-1:0] up_tag;
    logic               up_hit;
    logic               up_pred_taken;
    logic               mispredict;
    logic [CTRBITS-1:0] alloc_ctr;
    upd_action_e        action;

    // Instructions are 2 bytes, so bit 0 never takes part in indexing or tagging.
    logic unused_upd_pc_lsb;
    assign unused_upd_pc_lsb = UPD_PC[0];

    assign lk_idx = LK_PC[IDXBITS:1];
    assign lk_tag = LK_PC[DBITS-1:IDXBITS+1];
    assign lk_hit = valid[lk_idx] && (tags[lk_idx] == lk_tag);

    assign PRED_TAKEN  = lk_hit && ctrs[lk_idx][CTRBITS-1];
    assign PRED_TARGET = PRED_TAKEN ? targets[lk_idx] : LK_PC + DBITS'(2);

    assign up_idx        = UPD_PC[IDXBITS:1];
    assign up_tag        = UPD_PC[DBITS-1:IDXBITS+1];
    assign up_hit        = valid[up_idx] && (tags[up_idx] == up_tag);
    assign up_pred_taken = up_hit && ctrs[up_idx][CTRBITS-1];

    assign mispredict = (up_pred_taken != UPD_TAKEN) ||
                        (up_pred_taken && UPD_TAKEN && (targets[up_idx] != UPD_TARGET));

    // Fresh conditional branches start weakly taken; jumps start strongly taken.
    assign alloc_ctr = UPD_ISJMP ? {CTRBITS{1'b1}} : {1'b1, {(CTRBITS-1){1'b0}}};

    // Invalidate takes priority over any table write from a concurrent update.
    always_comb begin
        action = ACT_NONE;
        if (INV) begin
            action = ACT_FLUSH;
        end else if (UPD_VALID && up_hit) begin
            action = ACT_HIT;
        end else if (UPD_VALID && UPD_TAKEN) begin
            action = ACT_ALLOC;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tags[i]    <= '0;
                targets[i] <= '0;
            end
        end else begin
            case (action)
                ACT_FLUSH: valid <= '0;
                ACT_HIT: begin
                    if (UPD_TAKEN) begin
                        targets[up_idx] <= UPD_TARGET;
                    end
                end
                ACT_ALLOC: begin
                    valid[up_idx]   <= 1'b1;
                    tags[up_idx]    <= up_tag;
                    targets[up_idx] <= UPD_TARGET;
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        logic sel;
        assign sel = (up_idx == IDXBITS'(i));

        sat_counter #(
            .WIDTH(CTRBITS)
        ) u_ctr (
            .clk        (CLK),
            .rst_n      (RESET_N),
            .inc        (sel && (action == ACT_HIT) && UPD_TAKEN),
            .dec        (sel && (action == ACT_HIT) && !UPD_TAKEN),
            .force_max  (sel && (action == ACT_HIT) && UPD_ISJMP),
            .load       (sel && (action == ACT_ALLOC)),
            .load_value (alloc_ctr),
            .count      (ctrs[i])
        );
    end

    // Statistics count every update, including ones whose table write is suppressed.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            UPD_CNT  <= '0;
            MISP_CNT <= '0;
        end else if (UPD_VALID) begin
            if (UPD_CNT != {STATBITS{1'b1}}) begin
                UPD_CNT <= UPD_CNT + 1'b1;
            end
            if (mispredict && (MISP_CNT != {STATBITS{1'b1}})) begin
                MISP_CNT <= MISP_CNT + 1'b1;
            end
        end
    end

endmodule
